inst_issue_queue: RTL and testbench

- Parametrised instruction buffer between the fetch stage and the decode stage of the dual-issue SPU.
- Fetch pushes up to ISSUE_WIDTH sequential instructions per cycle. Decode pops 0..ISSUE_WIDTH instructions per cycle, in order, according to how many it could issue.
- The queue decouples fetch stalls from dependency stalls. Branch-taken flush empties it in one cycle.

---
 rtl/iq_if.sv | 26 ++
 rtl/inst_issue_queue.sv | 101 ++++++++++
 tb/tb_inst_issue_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_if.sv
// Fetch/decode side bundle of the instruction issue queue: push group in, head window out.
interface iq_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int INST_W      = 32,
    parameter int PC_W        = 32
);
    logic                          push_valid;
    logic [2:0]                    push_count;
    logic [ISSUE_WIDTH*INST_W-1:0] push_inst;
    logic [PC_W-1:0]               push_pc;
    logic                          push_ready;
    logic [2:0]                    pop_count;
    logic [ISSUE_WIDTH*INST_W-1:0] head_inst;
    logic [ISSUE_WIDTH*PC_W-1:0]   head_pc;
    logic [ISSUE_WIDTH-1:0]        head_valid;

    modport master (
        output push_valid, push_count, push_inst, push_pc, pop_count,
        input  push_ready, head_inst, head_pc, head_valid
    );

    modport slave (
        input  push_valid, push_count, push_inst, push_pc, pop_count,
        output push_ready, head_inst, head_pc, head_valid
    );
endinterface

// File: rtl/inst_issue_queue.sv
// Circular instruction buffer between fetch and decode; multi-slot push/pop per cycle,
// one-cycle flush, sticky overflow/underflow flags.
module inst_issue_queue #(
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int INST_W      = 32,
    parameter int PC_W        = 32,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    iq_if.slave              bus,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free_count,
    output logic             overflow_err,
    output logic             underflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    // Common compare width wide enough for the 3-bit request fields and the counter.
    localparam int AW = (CNT_W > 3) ? CNT_W : 3;
    localparam logic [AW-1:0] IW_A = AW'(ISSUE_WIDTH);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [AW-1:0] cnt_ext;
    logic [AW-1:0] push_ext;
    logic [AW-1:0] pop_ext;
    logic [AW-1:0] eff_pop;
    logic          push_len_ok;
    logic          push_acc;
    logic          push_rej;
    logic          pop_bad;
    logic [CNT_W-1:0] count_next;

    assign cnt_ext  = AW'(count);
    assign push_ext = AW'(bus.push_count);
    assign pop_ext  = AW'(bus.pop_count);

    assign free_count     = CNT_W'(DEPTH) - count;
    assign bus.push_ready = free_count >= CNT_W'(ISSUE_WIDTH);

    assign push_len_ok = (push_ext != '0) && (push_ext <= IW_A);
    assign push_acc    = bus.push_valid && bus.push_ready && push_len_ok && !flush && !reset;
    assign push_rej    = bus.push_valid && !flush && !(bus.push_ready && push_len_ok);
    assign pop_bad     = !flush && ((pop_ext > cnt_ext) || (pop_ext > IW_A));

    always_comb begin
        eff_pop = pop_ext;
        if (eff_pop > cnt_ext) eff_pop = cnt_ext;
        if (eff_pop > IW_A)    eff_pop = IW_A;
    end

    assign count_next = CNT_W'(cnt_ext + (push_acc ? push_ext : '0) - eff_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_W'(push_ext);
            rd_ptr <= rd_ptr + PTR_W'(eff_pop);
            count  <= count_next;
            if (push_rej) overflow_err  <= 1'b1;
            if (pop_bad)  underflow_err <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; head outputs mask stale entries by count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (push_acc && (AW'(i) < push_ext)) begin
                mem_inst[wr_ptr + PTR_W'(i)] <= bus.push_inst[i*INST_W +: INST_W];
                mem_pc[wr_ptr + PTR_W'(i)]   <= bus.push_pc + PC_W'(4 * i);
            end
        end
    end

    always_comb begin
        bus.head_inst  = '0;
        bus.head_pc    = '0;
        bus.head_valid = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (cnt_ext > AW'(i)) begin
                bus.head_valid[i]                  = 1'b1;
                bus.head_inst[i*INST_W +: INST_W]  = mem_inst[rd_ptr + PTR_W'(i)];
                bus.head_pc[i*PC_W +: PC_W]        = mem_pc[rd_ptr + PTR_W'(i)];
            end
        end
    end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: a queue-based reference model predicts the
// post-edge state, a negedge monitor compares it against the DUT.
module tb_inst_issue_queue;
    localparam int IW     = 2;
    localparam int DEPTH  = 8;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ent_t;

    typedef struct {
        int                   cyc;
        logic [CNT_W-1:0]     cnt;
        logic [CNT_W-1:0]     fcnt;
        logic [IW*INST_W-1:0] hi;
        logic [IW*PC_W-1:0]   hp;
        logic [IW-1:0]        hv;
        logic                 pr;
        logic                 ov;
        logic                 un;
    } snap_t;

    logic clock;
    logic reset;
    logic flush;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_count;
    logic overflow_err;
    logic underflow_err;

    iq_if #(.ISSUE_WIDTH(IW), .INST_W(INST_W), .PC_W(PC_W)) bus ();

    inst_issue_queue #(
        .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus),
        .count(count), .free_count(free_count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    ent_t  mq[$];
    logic  m_ov, m_un;
    snap_t sb[$];
    int    cyc_count = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc_count <= cyc_count + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc_count, act, exp);
        end
    endtask

    function automatic snap_t model_snap(input int c);
        snap_t s;
        s.cyc  = c;
        s.cnt  = CNT_W'(mq.size());
        s.fcnt = CNT_W'(DEPTH - mq.size());
        s.hi   = '0;
        s.hp   = '0;
        s.hv   = '0;
        for (int i = 0; i < IW; i++) begin
            if (i < mq.size()) begin
                s.hi[i*INST_W +: INST_W] = mq[i].inst;
                s.hp[i*PC_W +: PC_W]     = mq[i].pc;
                s.hv[i]                  = 1'b1;
            end
        end
        s.pr = (DEPTH - mq.size()) >= IW;
        s.ov = m_ov;
        s.un = m_un;
        return s;
    endfunction

    // Monitor: compares each predicted post-edge state once the DUT has settled.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
            snap_t e;
            e = sb.pop_front();
            if (e.cyc < cyc_count) begin
                check("sb_missed", 128'(e.cyc), 128'(cyc_count));
            end else begin
                check("count",         128'(count),          128'(e.cnt));
                check("free_count",    128'(free_count),     128'(e.fcnt));
                check("head_inst",     128'(bus.head_inst),  128'(e.hi));
                check("head_pc",       128'(bus.head_pc),    128'(e.hp));
                check("head_valid",    128'(bus.head_valid), 128'(e.hv));
                check("push_ready",    128'(bus.push_ready), 128'(e.pr));
                check("overflow_err",  128'(overflow_err),   128'(e.ov));
                check("underflow_err", 128'(underflow_err),  128'(e.un));
            end
        end
    end

    task automatic step(input logic rst, input logic fl, input logic pv, input int pcnt,
                        input logic [IW*INST_W-1:0] inst, input logic [PC_W-1:0] ppc,
                        input int popc);
        int eff;
        reset          = rst;
        flush          = fl;
        bus.push_valid = pv;
        bus.push_count = 3'(pcnt);
        bus.push_inst  = inst;
        bus.push_pc    = ppc;
        bus.pop_count  = 3'(popc);
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            bit ready;
            ready = (DEPTH - mq.size()) >= IW;
            if (popc > mq.size() || popc > IW) m_un = 1'b1;
            eff = popc;
            if (eff > mq.size()) eff = mq.size();
            if (eff > IW) eff = IW;
            if (pv) begin
                if (ready && pcnt >= 1 && pcnt <= IW) begin
                    for (int i = 0; i < pcnt; i++)
                        mq.push_back('{inst: inst[i*INST_W +: INST_W], pc: ppc + PC_W'(4 * i)});
                end else begin
                    m_ov = 1'b1;
                end
            end
            repeat (eff) void'(mq.pop_front());
        end
        sb.push_back(model_snap(cyc_count + 1));
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int popc);
        step(1'b0, 1'b0, 1'b0, 0, '0, '0, popc);
    endtask

    task automatic push(input int pcnt, input logic [IW*INST_W-1:0] inst,
                        input logic [PC_W-1:0] ppc, input int popc);
        step(1'b0, 1'b0, 1'b1, pcnt, inst, ppc, popc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        m_ov = 1'b0;
        m_un = 1'b0;

        // Basic push of two groups and in-order drain.
        step(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
        check("reset_free", 128'(free_count), 128'(DEPTH));
        check("reset_ready", 128'(bus.push_ready), 128'(1));
        push(2, {32'hBBBB_000B, 32'hAAAA_000A}, 32'h100, 0);
        push(2, {32'hDDDD_000D, 32'hCCCC_000C}, 32'h108, 0);
        check("t1_count", 128'(count), 128'(4));
        check("t1_head_inst", 128'(bus.head_inst), 128'({32'hBBBB_000B, 32'hAAAA_000A}));
        check("t1_head_pc", 128'(bus.head_pc), 128'({32'h104, 32'h100}));
        check("t1_head_valid", 128'(bus.head_valid), 128'(2'b11));
        idle(1);
        idle(1);
        idle(1);
        check("t2_one_valid", 128'(bus.head_valid), 128'(2'b01));
        check("t2_slot1_zero", 128'(bus.head_inst[63:32]), 128'(0));
        check("t2_slot0_D", 128'(bus.head_inst[31:0]), 128'(32'hDDDD_000D));
        check("t2_pc_D", 128'(bus.head_pc[31:0]), 128'(32'h10C));
        idle(1);
        check("t2_empty", 128'(count), 128'(0));
        check("t2_no_underflow", 128'(underflow_err), 128'(0));

        // Fill to 7, rejected push alongside a pop, then refill.
        push(2, {32'h2, 32'h1}, 32'h400, 0);
        push(2, {32'h4, 32'h3}, 32'h408, 0);
        push(2, {32'h6, 32'h5}, 32'h410, 0);
        push(1, {32'h0, 32'h7}, 32'h418, 0);
        check("t3_count7", 128'(count), 128'(7));
        check("t3_not_ready", 128'(bus.push_ready), 128'(0));
        push(2, {32'hEE, 32'hEE}, 32'h500, 2);
        check("t3_overflow", 128'(overflow_err), 128'(1));
        check("t3_count5", 128'(count), 128'(5));
        push(2, {32'h9, 32'h8}, 32'h41C, 0);
        check("t3_count7b", 128'(count), 128'(7));
        check("t3_head", 128'(bus.head_inst), 128'({32'h4, 32'h3}));

        // Wrap-around with steady push 2 / pop 2.
        step(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
        w = 32'h1000;
        push(2, {w + 32'd1, w}, 32'h0, 0);
        w = w + 2;
        for (int k = 0; k < 20; k++) begin
            push(2, {w + 32'd1, w}, 32'(8 * k), 2);
            w = w + 2;
        end
        check("t4_count2", 128'(count), 128'(2));
        check("t4_seq", 128'(bus.head_inst), 128'({w - 32'd1, w - 32'd2}));

        // Flush with simultaneous push/pop.
        step(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
        push(2, {32'h12, 32'h11}, 32'h20, 0);
        push(2, {32'h14, 32'h13}, 32'h28, 0);
        push(1, {32'h0, 32'h15}, 32'h30, 0);
        step(1'b0, 1'b1, 1'b1, 2, {32'h77, 32'h66}, 32'h40, 1);
        check("t5_count0", 128'(count), 128'(0));
        check("t5_hv0", 128'(bus.head_valid), 128'(0));
        check("t5_ready", 128'(bus.push_ready), 128'(1));
        push(1, {32'h0, 32'h5A5A_0001}, 32'h200, 0);
        check("t5_slot0", 128'(bus.head_inst[31:0]), 128'(32'h5A5A_0001));

        // Underflow stickiness.
        idle(2);
        check("t6_underflow", 128'(underflow_err), 128'(1));
        check("t6_count0", 128'(count), 128'(0));
        step(1'b0, 1'b1, 1'b0, 0, '0, '0, 0);
        check("t6_persist", 128'(underflow_err), 128'(1));
        step(1'b1, 1'b0, 1'b0, 0, '0, '0, 0);
        check("t6_cleared", 128'(underflow_err), 128'(0));

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            int r, pc_n, pop_n;
            logic pv;
            r     = $urandom_range(0, 99);
            pv    = ($urandom_range(0, 2) != 0);
            pc_n  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, IW);
            pop_n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, IW);
            step(r < 1, (r >= 1) && (r < 5), pv, pc_n, {$urandom(), $urandom()},
                 $urandom(), pop_n);
        end

        idle(0);
        @(negedge clock);
        #1;
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
